// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the master-arbiter FSM state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    // Non-cacheable, non-bufferable, privileged data access
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ahb3lite_rr_arb.sv
// Two-requester grant logic; round-robin by default, requester 0 fixed
// priority when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb3lite_rr_arb (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    assign gnt_vld = |req;

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic unused_ctl;
    assign unused_ctl = ^{HCLK, HRESETn, upd, upd_idx};

    assign gnt_idx = ~req[0];
`else
    logic prio;
    logic prio_eff;

    // A completing transfer hands priority to the other requester in the
    // same cycle, so back-to-back arbitration already sees the new pointer.
    assign prio_eff = upd ? ~upd_idx : prio;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prio <= 1'b0;
        end else if (upd) begin
            prio <= ~upd_idx;
        end
    end

    always_comb begin
        gnt_idx = req[1];
        if (req == 2'b11) begin
            gnt_idx = prio_eff;
        end
    end
`endif

endmodule

// File: rtl/ahb3lite_mst_arb.sv
// Two-port AHB3-Lite master arbiter issuing single, non-overlapped transfers.
// Build option: AHB_ARB_FIXED_PRIO_EN selects fixed priority for requester 0.
module ahb3lite_mst_arb
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [HADDR_SIZE-1:0] addr0,
    input  logic [HADDR_SIZE-1:0] addr1,
    input  logic [HDATA_SIZE-1:0] wdata0,
    input  logic [HDATA_SIZE-1:0] wdata1,
    input  logic [2:0]            size0,
    input  logic [2:0]            size1,
    output logic [1:0]            ack,
    output logic                  err,
    output logic [HDATA_SIZE-1:0] rdata,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADYOUT,
    input  logic                  HRESP
);

    arb_state_t            state;
    logic                  gnt;
    logic [HDATA_SIZE-1:0] lat_wdata;

    logic                  done;
    logic                  arb_vld;
    logic                  arb_idx;
    logic [HADDR_SIZE-1:0] sel_addr;
    logic [HDATA_SIZE-1:0] sel_wdata;
    logic [2:0]            sel_size;

    assign done = (state == ST_DATA) && HREADYOUT;

    ahb3lite_rr_arb u_arb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (req),
        .upd     (done),
        .upd_idx (gnt),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    assign sel_addr  = arb_idx ? addr1  : addr0;
    assign sel_wdata = arb_idx ? wdata1 : wdata0;
    assign sel_size  = arb_idx ? size1  : size0;

    // Completion is reported in the data-phase cycle itself to keep the
    // req-to-ack latency at two cycles for a zero-wait slave.
    assign ack    = done ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign err    = done & HRESP;
    assign rdata  = done ? HRDATA : '0;

    assign HREADY = HREADYOUT;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DEFAULT;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            lat_wdata <= '0;
            HSEL      <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWDATA    <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= HSIZE_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        gnt       <= arb_idx;
                        lat_wdata <= sel_wdata;
                        HSEL      <= 1'b1;
                        HTRANS    <= HTRANS_NONSEQ;
                        HADDR     <= sel_addr;
                        HWRITE    <= we[arb_idx];
                        HSIZE     <= sel_size;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    HSEL   <= 1'b0;
                    HTRANS <= HTRANS_IDLE;
                    HWDATA <= lat_wdata;
                    state  <= ST_DATA;
                end
                ST_DATA: begin
                    // Waiting (including the first ERROR cycle) holds HTRANS at IDLE
                    if (HREADYOUT) begin
                        if (arb_vld) begin
                            gnt       <= arb_idx;
                            lat_wdata <= sel_wdata;
                            HSEL      <= 1'b1;
                            HTRANS    <= HTRANS_NONSEQ;
                            HADDR     <= sel_addr;
                            HWRITE    <= we[arb_idx];
                            HSIZE     <= sel_size;
                            state     <= ST_ADDR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_mst_arb.sv
// Directed bench for ahb3lite_mst_arb with a small word-addressed slave model.
module tb_ahb3lite_mst_arb;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [2:0]  size0, size1;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int n_chk = 0;
    int n_err = 0;

    ahb3lite_mst_arb #(.HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .size0(size0), .size1(size1),
        .ack(ack), .err(err), .rdata(rdata),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: capture address phase, write/read memory in data phase
    logic [31:0] mem [16];
    logic        dph_v;
    logic        dph_w;
    logic [15:0] dph_a;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_v <= 1'b0;
            dph_w <= 1'b0;
            dph_a <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (dph_v && HREADYOUT) begin
                if (dph_w && !HRESP) mem[dph_a[5:2]] <= HWDATA;
                dph_v <= 1'b0;
            end
            if (HSEL && HTRANS == 2'b10 && HREADY) begin
                dph_v <= 1'b1;
                dph_w <= HWRITE;
                dph_a <= HADDR;
            end
        end
    end

    assign HRDATA = dph_v ? mem[dph_a[5:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        #1;
    endtask

    // One single transfer from requester r, started from IDLE
    task automatic xfer(input int r, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [2:0] sz,
                        input int waits, input logic resp, input logic [31:0] exp_rd);
        req[r] = 1'b1;
        we[r]  = w;
        if (r == 0) begin addr0 = a; wdata0 = d; size0 = sz; end
        else        begin addr1 = a; wdata1 = d; size1 = sz; end
        #1;
        check("idle_ack", 32'(ack), 32'd0);
        step();
        check("addr_htrans", 32'(HTRANS), 32'd2);
        check("addr_hsel",   32'(HSEL),   32'd1);
        check("addr_haddr",  32'(HADDR),  32'(a));
        check("addr_hwrite", 32'(HWRITE), 32'(w));
        check("addr_hsize",  32'(HSIZE),  32'(sz));
        step();
        for (int i = 0; i < waits; i++) begin
            HREADYOUT = 1'b0;
            HRESP     = resp && (i == waits - 1);
            #1;
            check("wait_htrans", 32'(HTRANS), 32'd0);
            check("wait_ack",    32'(ack),    32'd0);
            step();
        end
        HREADYOUT = 1'b1;
        HRESP     = resp;
        #1;
        check("data_htrans", 32'(HTRANS), 32'd0);
        check("data_ack",    32'(ack),    (r == 0) ? 32'd1 : 32'd2);
        check("data_err",    32'(err),    32'(resp));
        if (w) check("data_hwdata", HWDATA, d);
        if (!w && !resp) check("data_rdata", rdata, exp_rd);
        req = 2'b00;
        step();
        HRESP = 1'b0;
        #1;
        check("post_htrans", 32'(HTRANS), 32'd0);
        check("post_ack",    32'(ack),    32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hsel"},   32'(HSEL),   32'd0);
        check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        check({tag, "_haddr"},  32'(HADDR),  32'd0);
        check({tag, "_hwdata"}, HWDATA,      32'd0);
        check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        check({tag, "_hsize"},  32'(HSIZE),  32'd2);
        check({tag, "_ack"},    32'(ack),    32'd0);
        check({tag, "_err"},    32'(err),    32'd0);
        check({tag, "_rdata"},  rdata,       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g [4];
`ifdef AHB_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        HRESETn = 1'b0; req = '0; we = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        size0 = 3'd2; size1 = 3'd2;
        HREADYOUT = 1'b1; HRESP = 1'b0;

        step();
        step();
        check_reset_vals("rst");
        check("rst_hburst", 32'(HBURST), 32'd0);
        check("rst_hprot",  32'(HPROT),  32'd3);
        HRESETn = 1'b1;
        step();

        xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 3'b010, 0, 1'b0, 32'h0);
        xfer(0, 1'b0, 16'h0010, 32'h0,        3'b010, 0, 1'b0, 32'hDEADBEEF);
        xfer(1, 1'b1, 16'h0020, 32'hCAFEF00D, 3'b001, 0, 1'b0, 32'h0);
        xfer(1, 1'b0, 16'h0020, 32'h0,        3'b001, 3, 1'b0, 32'hCAFEF00D);
        xfer(0, 1'b0, 16'h0030, 32'h0,        3'b010, 1, 1'b1, 32'h0);

        // Reset while a write from requester 1 sits in a wait-stated data phase
        req[1] = 1'b1; we[1] = 1'b1; addr1 = 16'h0024; wdata1 = 32'h12345678; size1 = 3'b000;
        step();
        step();
        HREADYOUT = 1'b0;
        #1;
        check("rstd_hwdata_pre", HWDATA, 32'h12345678);
        check("rstd_ack_pre", 32'(ack), 32'd0);
        HRESETn = 1'b0;
        HREADYOUT = 1'b1;
        #1;
        check_reset_vals("rstd");
        req = 2'b00;
        step();
        HRESETn = 1'b1;
        step();

        // Contention from a fresh pointer: both requesters held for four transfers
        req = 2'b11; we = 2'b00; addr0 = 16'h0010; addr1 = 16'h0020;
        size0 = 3'b010; size1 = 3'b010;
        step();
        for (int k = 0; k < 4; k++) begin
            check("cont_htrans", 32'(HTRANS), 32'd2);
            check("cont_haddr",  32'(HADDR),  (exp_g[k] == 1) ? 32'h20 : 32'h10);
            step();
            check("cont_ack", 32'(ack), (exp_g[k] == 1) ? 32'd2 : 32'd1);
            if (k == 3) req = 2'b00;
            step();
        end
        check("cont_end_htrans", 32'(HTRANS), 32'd0);
        check("cont_end_ack",    32'(ack),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
